// File: rtl/fm_block_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fm_block_ram: EBOX fast memory, 128 x 36, single port, per-lane writes,  |
// | write-first registered read. Option FM_INIT_CLEAR_EN: clear on reset.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fm_block_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 36,
  parameter int LANE_W = 9,
  parameter int LANES  = 4
) (
  input  logic              clka,
  input  logic              reset,
  input  logic [0:ADDR_W-1] addra,
  input  logic [0:DATA_W-1] dina,
  input  logic [0:LANES-1]  wea,
  output logic [0:DATA_W-1] douta,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [0:DATA_W-1] mem [0:DEPTH-1];
  logic [0:DATA_W-1] rd_merged;

  // Write-first: enabled lanes of the read word come straight from dina.
  always_comb begin
    rd_merged = mem[addra];
    for (int i = 0; i < LANES; i++) begin
      if (wea[i]) begin
        rd_merged[i*LANE_W +: LANE_W] = dina[i*LANE_W +: LANE_W];
      end
    end
  end

`ifdef FM_INIT_CLEAR_EN
  logic [0:ADDR_W-1] clr_cnt;

  // Sweeps all words once after reset; busy drops after the last word.
  always_ff @(posedge clka) begin
    if (reset) begin
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) begin
        busy <= 1'b0;
      end
    end
  end
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clka) begin
    if (reset) begin
      douta <= '0;
    end else if (busy) begin
      douta <= '0;
`ifdef FM_INIT_CLEAR_EN
      mem[clr_cnt] <= '0;
`endif
    end else begin
      douta <= rd_merged;
      for (int i = 0; i < LANES; i++) begin
        if (wea[i]) begin
          mem[addra][i*LANE_W +: LANE_W] <= dina[i*LANE_W +: LANE_W];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fm_block_ram.sv
`default_nettype none
// Testbench for fm_block_ram: vector table, randomized model check, reset sequences.
module tb_fm_block_ram;

  logic        clka = 1'b0;
  logic        reset = 1'b1;
  logic [0:6]  addra = '0;
  logic [0:35] dina = '0;
  logic [0:3]  wea = '0;
  logic [0:35] douta;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [0:35] model [0:127];

  typedef struct {
    logic [0:3]  wea;
    logic [0:6]  addr;
    logic [0:35] din;
    logic [0:35] exp;
  } vec_t;

  vec_t vecs [0:15];

  fm_block_ram dut (
    .clka  (clka),
    .reset (reset),
    .addra (addra),
    .dina  (dina),
    .wea   (wea),
    .douta (douta),
    .busy  (busy)
  );

  always #5 clka = ~clka;

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic check(input string nm, input logic [0:35] act, input logic [0:35] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %o expected %o", nm, act, exp);
    end
  endtask

  function automatic logic [0:35] merge(input logic [0:35] old, input logic [0:35] din,
                                        input logic [0:3] w);
    logic [0:35] mask;
    mask = {{9{w[0]}}, {9{w[1]}}, {9{w[2]}}, {9{w[3]}}};
    return (old & ~mask) | (din & mask);
  endfunction

  task automatic access(input logic [0:3] w, input logic [0:6] a, input logic [0:35] d,
                        input logic [0:35] exp, input string nm);
    wea = w; addra = a; dina = d;
    step();
    check(nm, douta, exp);
  endtask

  // After reset has been sampled: ride out any init clear and check its length.
  task automatic wait_idle(input string nm);
    int n;
    n = 0;
`ifdef FM_INIT_CLEAR_EN
    while (busy === 1'b1 && n < 200) begin
      step();
      n++;
      check({nm, "_busy_douta"}, douta, 36'o0);
    end
    check({nm, "_busy_cycles"}, 36'(n), 36'd128);
`else
    check({nm, "_busy_low"}, {35'd0, busy}, 36'd0);
`endif
  endtask

  initial begin
    logic [63:0] r;
    logic [0:35] d, e;
    logic [0:3]  w;
    logic [0:6]  a;

    vecs[0]  = '{4'b1111, 7'o005, 36'o123456701234, 36'o123456701234};
    vecs[1]  = '{4'b0000, 7'o005, 36'o0,            36'o123456701234};
    vecs[2]  = '{4'b1111, 7'o017, 36'o777777777777, 36'o777777777777};
    vecs[3]  = '{4'b0011, 7'o017, 36'o0,            36'o777777000000};
    vecs[4]  = '{4'b0000, 7'o017, 36'o0,            36'o777777000000};
    vecs[5]  = '{4'b1100, 7'o017, 36'o0,            36'o0};
    vecs[6]  = '{4'b0000, 7'o017, 36'o0,            36'o0};
    vecs[7]  = '{4'b1111, 7'o000, 36'o1,            36'o1};
    vecs[8]  = '{4'b1111, 7'o177, 36'o2,            36'o2};
    vecs[9]  = '{4'b0000, 7'o000, 36'o0,            36'o1};
    vecs[10] = '{4'b0000, 7'o177, 36'o0,            36'o2};
    vecs[11] = '{4'b1111, 7'o040, 36'o555555555555, 36'o555555555555};
    vecs[12] = '{4'b1000, 7'o040, 36'o0,            36'o000555555555};
    vecs[13] = '{4'b0100, 7'o005, 36'o777777777777, 36'o123777701234};
    vecs[14] = '{4'b0000, 7'o040, 36'o0,            36'o000555555555};
    vecs[15] = '{4'b0000, 7'o005, 36'o0,            36'o123777701234};

    // Power-on reset
    reset = 1'b1; wea = 4'b1111; addra = 7'o005; dina = 36'o7;
    step();
    check("reset_douta", douta, 36'o0);
`ifdef FM_INIT_CLEAR_EN
    check("reset_busy", {35'd0, busy}, 36'd1);
`else
    check("reset_busy", {35'd0, busy}, 36'd0);
`endif
    reset = 1'b0;
    wait_idle("por");

    for (int i = 0; i < 16; i++) begin
      access(vecs[i].wea, vecs[i].addr, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Fill every word, then random lane-masked traffic against the model
    for (int i = 0; i < 128; i++) begin
      r = {$urandom, $urandom};
      d = r[35:0];
      model[i] = d;
      access(4'b1111, 7'(i), d, d, $sformatf("fill%0d", i));
    end
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom};
      d = r[35:0];
      w = 4'($urandom_range(0, 15));
      a = 7'($urandom_range(0, 127));
      e = merge(model[a], d, w);
      model[a] = e;
      access(w, a, d, e, $sformatf("rand%0d_a%o_w%b", i, a, w));
    end

    // Reset with a simultaneous write: write inhibited, douta cleared
    access(4'b1111, 7'o100, 36'o7, 36'o7, "pre_reset_wr");
    model[7'o100] = 36'o7;
    reset = 1'b1; wea = 4'b1111; addra = 7'o003; dina = 36'o777777777777;
    step();
    check("rst_wr_douta", douta, 36'o0);
    reset = 1'b0;
`ifdef FM_INIT_CLEAR_EN
    wea = 4'b1111; addra = 7'o100; dina = 36'o7;
    wait_idle("clr");
    access(4'b0000, 7'o100, 36'o0, 36'o0, "clr_read100");
    access(4'b0000, 7'o003, 36'o0, 36'o0, "clr_read3");
    access(4'b0000, 7'o177, 36'o0, 36'o0, "clr_read177");
`else
    wait_idle("rst2");
    access(4'b0000, 7'o003, 36'o0, model[3], "retain3");
    access(4'b0000, 7'o100, 36'o0, 36'o7, "retain100");
`endif
    access(4'b1111, 7'o003, 36'o42, 36'o42, "post_rst_wr");
    access(4'b0000, 7'o003, 36'o0, 36'o42, "post_rst_rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
